// File: rtl/layer_pkg.sv
// layer_pkg: shared state encoding and default sizing for the layer host sequencer.
package layer_pkg;
    localparam int DEF_ADDR_WIDTH  = 10;
    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_VECTOR_LEN  = 16;
    localparam int DEF_NUM_NEURONS = 16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_TOK,
        S_LOAD_WGT,
        S_START,
        S_WAIT_DONE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_OUT,
        S_FINISH
    } seq_state_t;
endpackage

// File: rtl/layer_host_sequencer.sv
// layer_host_sequencer: streams tokens/weights into accelerator memories, starts a layer,
// then drains the result memory onto a valid/ready stream.
module layer_host_sequencer
    import layer_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int VECTOR_LEN  = DEF_VECTOR_LEN,
    parameter int NUM_NEURONS = DEF_NUM_NEURONS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_go,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] out_data,
    output logic                    out_last,
    output logic                    token_wr_en,
    output logic [ADDR_WIDTH-1:0]   token_wr_addr,
    output logic [DATA_WIDTH-1:0]   token_wr_data,
    output logic                    weight_wr_en,
    output logic [ADDR_WIDTH-1:0]   weight_wr_addr,
    output logic [DATA_WIDTH-1:0]   weight_wr_data,
    output logic                    start,
    input  logic                    layer_busy,
    input  logic                    layer_done,
    output logic                    result_rd_en,
    output logic [ADDR_WIDTH-1:0]   result_rd_addr,
    input  logic [2*DATA_WIDTH-1:0] result_rd_data,
    output logic                    seq_busy,
    output logic                    job_done
);
    localparam int TOTAL = VECTOR_LEN * NUM_NEURONS;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam logic [CW-1:0] TOK_LAST = CW'(VECTOR_LEN - 1);
    localparam logic [CW-1:0] WGT_LAST = CW'(TOTAL - 1);
    localparam logic [CW-1:0] RES_LAST = CW'(NUM_NEURONS - 1);

    seq_state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, idx, idx_nxt;
    logic accept;
    logic unused_busy;

    assign unused_busy = layer_busy;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            out_data <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            if (state == S_RD_WAIT)
                out_data <= result_rd_data;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        case (state)
            S_IDLE: if (cmd_go) begin
                state_nxt = S_LOAD_TOK;
                cnt_nxt   = '0;
            end
            S_LOAD_TOK: if (accept) begin
                state_nxt = (cnt == TOK_LAST) ? S_LOAD_WGT : S_LOAD_TOK;
                cnt_nxt   = (cnt == TOK_LAST) ? '0 : cnt + 1'b1;
            end
            S_LOAD_WGT: if (accept) begin
                state_nxt = (cnt == WGT_LAST) ? S_START : S_LOAD_WGT;
                cnt_nxt   = (cnt == WGT_LAST) ? '0 : cnt + 1'b1;
            end
            S_START: state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (layer_done) begin
                state_nxt = S_RD_ISSUE;
                idx_nxt   = '0;
            end
            S_RD_ISSUE: state_nxt = S_RD_WAIT;
            S_RD_WAIT:  state_nxt = S_RD_OUT;
            S_RD_OUT: if (out_ready) begin
                state_nxt = out_last ? S_FINISH : S_RD_ISSUE;
                idx_nxt   = out_last ? idx : idx + 1'b1;
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Address/data buses are gated so every output rests at zero outside its active beat.
    assign in_ready       = (state == S_LOAD_TOK) || (state == S_LOAD_WGT);
    assign accept         = in_ready && in_valid;
    assign token_wr_en    = accept && (state == S_LOAD_TOK);
    assign token_wr_addr  = token_wr_en ? ADDR_WIDTH'(cnt) : '0;
    assign token_wr_data  = token_wr_en ? in_data : '0;
    assign weight_wr_en   = accept && (state == S_LOAD_WGT);
    assign weight_wr_addr = weight_wr_en ? ADDR_WIDTH'(cnt) : '0;
    assign weight_wr_data = weight_wr_en ? in_data : '0;
    assign start          = state == S_START;
    assign result_rd_en   = state == S_RD_ISSUE;
    assign result_rd_addr = result_rd_en ? ADDR_WIDTH'(idx) : '0;
    assign out_valid      = state == S_RD_OUT;
    assign out_last       = out_valid && (idx == RES_LAST);
    assign seq_busy       = state != S_IDLE;
    assign job_done       = state == S_FINISH;
endmodule

// File: doc/layer_host_sequencer.md
LAYER_HOST_SEQUENCER -- requirements
Module: layer_host_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, memory address width matching the accelerator memories.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, token/weight word width; results are 2*DATA_WIDTH.
REQ-003 SHALL have parameter VECTOR_LEN, default 16, tokens per job.
REQ-004 SHALL have parameter NUM_NEURONS, default 16, results per job; weights per job = VECTOR_LEN*NUM_NEURONS (must be <= 2**ADDR_WIDTH).
REQ-005 SHALL have ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-low reset.
- cmd_go  in  1  begin job (honoured in IDLE only).
- in_valid / in_ready  in / out  1 / 1  load-stream handshake.
- in_data  in  DATA_WIDTH  token or weight word.
- out_valid / out_ready  out / in  1 / 1  result-stream handshake.
- out_data  out  2*DATA_WIDTH  result word.
- out_last  out  1  marks final result of job.
- token_wr_en, token_wr_addr, token_wr_data  out  1, ADDR_WIDTH, DATA_WIDTH  token memory write.
- weight_wr_en, weight_wr_addr, weight_wr_data  out  1, ADDR_WIDTH, DATA_WIDTH  weight memory write.
- start  out  1  one-cycle accelerator start pulse.
- layer_busy, layer_done  in  1, 1  accelerator status.
- result_rd_en, result_rd_addr  out  1, ADDR_WIDTH  result memory read request.
- result_rd_data  in  2*DATA_WIDTH  read data, valid one cycle after result_rd_en.
- seq_busy  out  1  high in every state except IDLE.
- job_done  out  1  one-cycle pulse after last result accepted.

Function
REQ-006 SHALL implement states IDLE, LOAD_TOK, LOAD_WGT, START, WAIT_DONE, RD_ISSUE, RD_WAIT, RD_OUT, FINISH.
REQ-007 IDLE: cmd_go=1 -> LOAD_TOK, word counter cleared; cmd_go in any other state SHALL be ignored.
REQ-008 in_ready SHALL be 1 exactly in LOAD_TOK and LOAD_WGT; a beat is accepted when in_valid&&in_ready.
REQ-009 LOAD_TOK: on accepted beat, combinationally token_wr_en=1, token_wr_addr=counter, token_wr_data=in_data; counter increments; beat VECTOR_LEN-1 -> LOAD_WGT with counter cleared.
REQ-010 LOAD_WGT: same rule on weight port; beat i written to address i (i = neuron*VECTOR_LEN + element); final beat -> START.
REQ-011 in_valid gaps SHALL stall loading with no writes issued; wr_en SHALL never assert outside accepted beats.
REQ-012 START: start=1 for exactly one cycle -> WAIT_DONE.
REQ-013 WAIT_DONE: layer_done=1 sampled -> RD_ISSUE with result index cleared; wait is unbounded.
REQ-014 RD_ISSUE: result_rd_en=1, result_rd_addr=index for one cycle -> RD_WAIT.
REQ-015 RD_WAIT: result_rd_data SHALL be captured into out_data register -> RD_OUT.
REQ-016 RD_OUT: out_valid=1, out_data stable, out_last=(index==NUM_NEURONS-1); on out_ready: last -> FINISH, else index+1 -> RD_ISSUE.
REQ-017 Result throughput SHALL be one word per 3 cycles with out_ready held high.
REQ-018 FINISH: job_done=1 for one cycle -> IDLE; next cmd_go starts a fresh job from address 0.
REQ-019 Counters SHALL be $clog2-sized to hold VECTOR_LEN*NUM_NEURONS; addresses zero-extended to ADDR_WIDTH.

Reset
REQ-020 rst=0 at a clock edge SHALL force IDLE, clear counters, out_data=0, and drive every output to 0 (in_ready, out_valid, out_last, all wr_en/addr/data, start, result_rd_en/addr, seq_busy, job_done).
REQ-021 Reset mid-job SHALL abandon the job; partially written memory contents are not cleaned up.

Structure
REQ-022 State enum and default parameter constants SHALL live in shared package layer_pkg.
REQ-023 No sub-module; single flat FSM with load counter and result index. Verified against a layer_top instance.

Verification
REQ-024 16 tokens =1, 256 weights =2, out_ready=1 -> 16 results each 32, out_last on 16th only, one job_done pulse.
REQ-025 Write trace: token beat 5 -> token_wr_addr 5; weight beat 37 -> weight_wr_addr 37; in_valid low 3 cycles mid-load -> no wr_en during gap.
REQ-026 out_ready low 5 cycles at result 3 -> out_valid held, out_data unchanged, no result_rd_en until accepted.
REQ-027 cmd_go pulsed during WAIT_DONE -> no effect; start pulsed exactly once per job.
REQ-028 rst=0 during LOAD_WGT beat 100 -> all outputs 0 next cycle; new job with tokens 3, weights -1 -> 16 results each -48.
